// File: rtl/multicore_launch_ctrl_if.sv
// ---------------------------------------------------------------------------
// multicore_launch_ctrl_if
// Bundle of the host/core-facing signals of multicore_launch_ctrl.
//   go         host launch request
//   coreReady  per-core "idle, waiting for start"
//   coreDone   per-core completion
//   coreStart  per-core start pulse from the controller
//   busy       controller not idle
//   allDone    one-cycle end-of-run pulse
//   doneMask   sticky per-core done record for the current/last run
//   cycleCount run length in RUN cycles
//   timeout    watchdog flag (only with MULTICORE_LAUNCH_CTRL_TIMEOUT_EN)
// Modports:
//   master  host/core side (drives go, coreReady, coreDone)
//   slave   the launch controller
// Optional feature macro: MULTICORE_LAUNCH_CTRL_TIMEOUT_EN
// ---------------------------------------------------------------------------
interface multicore_launch_ctrl_if #(
    parameter int CORE_COUNT = 4,
    parameter int CNT_WIDTH  = 24
);
    logic                  go;
    logic [CORE_COUNT-1:0] coreReady;
    logic [CORE_COUNT-1:0] coreDone;
    logic [CORE_COUNT-1:0] coreStart;
    logic                  busy;
    logic                  allDone;
    logic [CORE_COUNT-1:0] doneMask;
    logic [CNT_WIDTH-1:0]  cycleCount;
`ifdef MULTICORE_LAUNCH_CTRL_TIMEOUT_EN
    logic                  timeout;

    modport master (
        output go, coreReady, coreDone,
        input  coreStart, busy, allDone, doneMask, cycleCount, timeout
    );
    modport slave (
        input  go, coreReady, coreDone,
        output coreStart, busy, allDone, doneMask, cycleCount, timeout
    );
`else
    modport master (
        output go, coreReady, coreDone,
        input  coreStart, busy, allDone, doneMask, cycleCount
    );
    modport slave (
        input  go, coreReady, coreDone,
        output coreStart, busy, allDone, doneMask, cycleCount
    );
`endif
endinterface

// File: rtl/multicore_launch_ctrl.sv
// ---------------------------------------------------------------------------
// multicore_launch_ctrl
// Launches an array of CORE_COUNT processor cores together, collects their
// done flags, pulses allDone when every core has finished and reports the run
// length (RUN cycles, saturating) in cycleCount.
// Ports:
//   clk   system clock, rising edge
//   rstN  asynchronous active-low reset
//   bus   multicore_launch_ctrl_if.slave (go, coreReady, coreDone in;
//         coreStart, busy, allDone, doneMask, cycleCount[, timeout] out)
// All outputs are registered.
// Optional feature macro: MULTICORE_LAUNCH_CTRL_TIMEOUT_EN adds the
// TIMEOUT_CYCLES parameter, the timeout output and a RUN watchdog.
// ---------------------------------------------------------------------------
module multicore_launch_ctrl #(
    parameter int CORE_COUNT = 4,
    parameter int CNT_WIDTH  = 24
`ifdef MULTICORE_LAUNCH_CTRL_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
`endif
) (
    input  logic                   clk,
    input  logic                   rstN,
    multicore_launch_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_RDY = 3'd1,
        ST_LAUNCH   = 3'd2,
        ST_RUN      = 3'd3,
        ST_FINISH   = 3'd4
    } state_t;

    state_t                state_r;
    state_t                nextState_s;
    logic [CORE_COUNT-1:0] coreStart_r;
    logic [CORE_COUNT-1:0] doneMask_r;
    logic                  busy_r;
    logic                  allDone_r;
    logic [CNT_WIDTH-1:0]  cycleCount_r;

    logic [CORE_COUNT-1:0] startNext_s;
    logic [CORE_COUNT-1:0] maskNext_s;
    logic [CORE_COUNT-1:0] mergedMask_s;
    logic                  busyNext_s;
    logic                  allDoneNext_s;
    logic [CNT_WIDTH-1:0]  countNext_s;
    logic [CNT_WIDTH-1:0]  countInc_s;
    logic                  allSeen_s;
    logic                  watchdog_s;

    // The edge that completes the mask is still part of the run, so the
    // finish decision looks at the mask including this cycle's done bits.
    assign mergedMask_s = doneMask_r | bus.coreDone;
    assign allSeen_s    = &mergedMask_s;
    assign countInc_s   = (&cycleCount_r) ? cycleCount_r : (cycleCount_r + CNT_WIDTH'(1));

`ifdef MULTICORE_LAUNCH_CTRL_TIMEOUT_EN
    // Compared at 64 bits so a limit wider than the counter never aliases.
    localparam longint unsigned TIMEOUT_LIMIT = 64'(TIMEOUT_CYCLES);

    logic timeout_r;
    logic timeoutNext_s;

    assign watchdog_s  = (64'(countInc_s) == TIMEOUT_LIMIT) && !allSeen_s;
    assign bus.timeout = timeout_r;
`else
    assign watchdog_s  = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= nextState_s;
        end
    end

    // Next-state logic.
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.go) begin
                    nextState_s = ST_WAIT_RDY;
                end else begin
                    nextState_s = ST_IDLE;
                end
            end
            ST_WAIT_RDY: begin
                if (&bus.coreReady) begin
                    nextState_s = ST_LAUNCH;
                end else begin
                    nextState_s = ST_WAIT_RDY;
                end
            end
            ST_LAUNCH: begin
                nextState_s = ST_RUN;
            end
            ST_RUN: begin
                if (allSeen_s || watchdog_s) begin
                    nextState_s = ST_FINISH;
                end else begin
                    nextState_s = ST_RUN;
                end
            end
            ST_FINISH: begin
                nextState_s = ST_IDLE;
            end
            default: begin
                nextState_s = ST_IDLE;
            end
        endcase
    end

    // Output logic: next values of the registered outputs, derived from the
    // upcoming state so every output is a flop.
    always_comb begin
        busyNext_s    = (nextState_s != ST_IDLE);
        allDoneNext_s = (nextState_s == ST_FINISH);
        maskNext_s    = doneMask_r;
        countNext_s   = cycleCount_r;
        if (nextState_s == ST_LAUNCH) begin
            startNext_s = {CORE_COUNT{1'b1}};
        end else begin
            startNext_s = {CORE_COUNT{1'b0}};
        end
        case (state_r)
            ST_IDLE: begin
                if (bus.go) begin
                    maskNext_s  = {CORE_COUNT{1'b0}};
                    countNext_s = {CNT_WIDTH{1'b0}};
                end else begin
                    maskNext_s  = doneMask_r;
                    countNext_s = cycleCount_r;
                end
            end
            ST_RUN: begin
                maskNext_s  = mergedMask_s;
                countNext_s = countInc_s;
            end
            default: begin
                maskNext_s  = doneMask_r;
                countNext_s = cycleCount_r;
            end
        endcase
    end

    // Output and run-record registers.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            coreStart_r  <= {CORE_COUNT{1'b0}};
            busy_r       <= 1'b0;
            allDone_r    <= 1'b0;
            doneMask_r   <= {CORE_COUNT{1'b0}};
            cycleCount_r <= {CNT_WIDTH{1'b0}};
        end else begin
            coreStart_r  <= startNext_s;
            busy_r       <= busyNext_s;
            allDone_r    <= allDoneNext_s;
            doneMask_r   <= maskNext_s;
            cycleCount_r <= countNext_s;
        end
    end

`ifdef MULTICORE_LAUNCH_CTRL_TIMEOUT_EN
    // Sticky watchdog flag: cleared by an accepted go, set when the watchdog ends a run.
    always_comb begin
        if ((state_r == ST_IDLE) && bus.go) begin
            timeoutNext_s = 1'b0;
        end else if ((state_r == ST_RUN) && watchdog_s) begin
            timeoutNext_s = 1'b1;
        end else begin
            timeoutNext_s = timeout_r;
        end
    end

    // Watchdog flag register.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            timeout_r <= 1'b0;
        end else begin
            timeout_r <= timeoutNext_s;
        end
    end
`endif

    assign bus.coreStart  = coreStart_r;
    assign bus.busy       = busy_r;
    assign bus.allDone    = allDone_r;
    assign bus.doneMask   = doneMask_r;
    assign bus.cycleCount = cycleCount_r;

endmodule

// File: tb/tb_multicore_launch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicore_launch_ctrl
// Self-checking bench for multicore_launch_ctrl: a 4-core/24-bit instance for
// launch, run and reset behaviour, and a 1-core/4-bit instance for counter
// saturation and the single-core case.
// ---------------------------------------------------------------------------
module tb_multicore_launch_ctrl;

    localparam int NC = 4;
    localparam int CW = 24;

    typedef struct packed {
        logic [7:0]         rdyDelay;   // cycles coreReady stays incomplete after go
        logic [NC-1:0][7:0] doneAt;     // RUN edge of first done per core, 0 = never
        logic [7:0]         expCount;   // RUN edge at which the run ends
        logic [NC-1:0]      expMask;    // doneMask at the end of the run
        logic               expTimeout;
    } vec_t;

    logic clk  = 1'b0;
    logic rstN = 1'b0;
    int   checks = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    multicore_launch_ctrl_if #(.CORE_COUNT(NC), .CNT_WIDTH(CW)) busM ();
    multicore_launch_ctrl_if #(.CORE_COUNT(1),  .CNT_WIDTH(4))  busS ();

    multicore_launch_ctrl #(
        .CORE_COUNT(NC),
        .CNT_WIDTH(CW)
`ifdef MULTICORE_LAUNCH_CTRL_TIMEOUT_EN
        , .TIMEOUT_CYCLES(20)
`endif
    ) dutMain (
        .clk (clk),
        .rstN(rstN),
        .bus (busM)
    );

    multicore_launch_ctrl #(
        .CORE_COUNT(1),
        .CNT_WIDTH(4)
`ifdef MULTICORE_LAUNCH_CTRL_TIMEOUT_EN
        , .TIMEOUT_CYCLES(100)
`endif
    ) dutSmall (
        .clk (clk),
        .rstN(rstN),
        .bus (busS)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act === exp) begin
            passed = passed + 1;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic releaseReset();
        @(negedge clk);
        rstN = 1'b1;
    endtask

    function automatic vec_t mkVec(input int rdy, input int d0, input int d1, input int d2,
                                   input int d3, input int cnt, input logic [NC-1:0] mask,
                                   input logic to);
        vec_t v;
        v.rdyDelay   = 8'(rdy);
        v.doneAt[0]  = 8'(d0);
        v.doneAt[1]  = 8'(d1);
        v.doneAt[2]  = 8'(d2);
        v.doneAt[3]  = 8'(d3);
        v.expCount   = 8'(cnt);
        v.expMask    = mask;
        v.expTimeout = to;
        return v;
    endfunction

    // One complete run on the main instance, starting and ending in IDLE.
    task automatic doRun(input vec_t v, input string tag);
        logic [NC-1:0] expMask;
        logic [NC-1:0] dn;
        bit            finished;
        expMask  = '0;
        finished = 1'b0;
        busM.go        = 1'b1;
        busM.coreReady = (v.rdyDelay != 8'd0) ? 4'b1011 : 4'b1111;
        busM.coreDone  = NC'($urandom);
        step();
        busM.go       = 1'b0;
        busM.coreDone = NC'($urandom);
        chk({tag, "/busyAfterGo"}, 32'(busM.busy), 32'd1);
        chk({tag, "/countCleared"}, 32'(busM.cycleCount), 32'd0);
        chk({tag, "/maskCleared"}, 32'(busM.doneMask), 32'd0);
        for (int i = 0; i < int'(v.rdyDelay); i++) begin
            chk({tag, "/noStartNotReady"}, 32'(busM.coreStart), 32'd0);
            busM.go = 1'($urandom);
            step();
        end
        busM.coreReady = 4'b1111;
        step();
        chk({tag, "/startHigh"}, 32'(busM.coreStart), 32'hF);
        busM.coreReady = NC'($urandom);
        busM.go        = 1'($urandom);
        step();
        chk({tag, "/startLow"}, 32'(busM.coreStart), 32'd0);
        chk({tag, "/countBeforeRun"}, 32'(busM.cycleCount), 32'd0);
        for (int n = 1; n <= 40 && !finished; n++) begin
            for (int c = 0; c < NC; c++) begin
                if (v.doneAt[c] == 8'd0) begin
                    dn[c] = 1'b0;
                end else if (int'(v.doneAt[c]) == n) begin
                    dn[c] = 1'b1;
                end else if (int'(v.doneAt[c]) < n) begin
                    dn[c] = 1'($urandom);
                end else begin
                    dn[c] = 1'b0;
                end
            end
            busM.coreDone = dn;
            busM.go       = 1'($urandom);
            expMask       = expMask | dn;
            step();
            chk({tag, "/runMask"}, 32'(busM.doneMask), 32'(expMask));
            chk({tag, "/runStart"}, 32'(busM.coreStart), 32'd0);
            if (n == int'(v.expCount)) begin
                chk({tag, "/allDone"}, 32'(busM.allDone), 32'd1);
                chk({tag, "/finalCount"}, 32'(busM.cycleCount), 32'(v.expCount));
                chk({tag, "/finalMask"}, 32'(busM.doneMask), 32'(v.expMask));
`ifdef MULTICORE_LAUNCH_CTRL_TIMEOUT_EN
                chk({tag, "/timeout"}, 32'(busM.timeout), 32'(v.expTimeout));
`endif
                finished = 1'b1;
            end else begin
                chk({tag, "/noEarlyDone"}, 32'(busM.allDone), 32'd0);
                chk({tag, "/runCount"}, 32'(busM.cycleCount), 32'(n));
            end
        end
        if (!finished) begin
            chk({tag, "/finishWithinBudget"}, 32'd0, 32'd1);
        end
        busM.go        = 1'b0;
        busM.coreReady = 4'b1111;
        busM.coreDone  = NC'($urandom);
        step();
        chk({tag, "/idleBusy"}, 32'(busM.busy), 32'd0);
        chk({tag, "/pulseOneCycle"}, 32'(busM.allDone), 32'd0);
        busM.coreDone = NC'($urandom);
        step();
        chk({tag, "/countHeld"}, 32'(busM.cycleCount), 32'(v.expCount));
        chk({tag, "/maskHeld"}, 32'(busM.doneMask), 32'(v.expMask));
        chk({tag, "/stillIdle"}, 32'(busM.busy), 32'd0);
        busM.coreDone = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        vec_t table_q[$];
        vec_t v;
        int   mx;

        busS.go = 1'b0; busS.coreReady = 1'b0; busS.coreDone = 1'b0;

        // Reset held with go and all cores ready: nothing may move.
        busM.go = 1'b1; busM.coreReady = 4'b1111; busM.coreDone = 4'b0000;
        step(); step(); step();
        chk("rst/busy", 32'(busM.busy), 32'd0);
        chk("rst/coreStart", 32'(busM.coreStart), 32'd0);
        chk("rst/allDone", 32'(busM.allDone), 32'd0);
        chk("rst/doneMask", 32'(busM.doneMask), 32'd0);
        chk("rst/cycleCount", 32'(busM.cycleCount), 32'd0);
        chk("rst/smallBusy", 32'(busS.busy), 32'd0);
`ifdef MULTICORE_LAUNCH_CTRL_TIMEOUT_EN
        chk("rst/timeout", 32'(busM.timeout), 32'd0);
`endif

        // Release with go held: normal launch, then async reset while coreStart is high.
        releaseReset();
        step();
        chk("rel/busy", 32'(busM.busy), 32'd1);
        busM.go = 1'b0;
        step();
        chk("rel/coreStart", 32'(busM.coreStart), 32'hF);
        #2 rstN = 1'b0;
        #1;
        chk("asyncRst/startDrops", 32'(busM.coreStart), 32'd0);
        chk("asyncRst/busyDrops", 32'(busM.busy), 32'd0);

        // Launch again, pulse go during RUN, then async reset mid-RUN.
        releaseReset();
        busM.go = 1'b1;
        step();
        busM.go = 1'b0;
        step();
        step();
        busM.go = 1'b1; step();
        busM.go = 1'b0; step();
        busM.go = 1'b1; step();
        busM.go = 1'b0;
        chk("midRun/count3", 32'(busM.cycleCount), 32'd3);
        chk("midRun/goIgnored", 32'(busM.coreStart), 32'd0);
        chk("midRun/busy", 32'(busM.busy), 32'd1);
        #2 rstN = 1'b0;
        #1;
        chk("midRunRst/busy", 32'(busM.busy), 32'd0);
        chk("midRunRst/count", 32'(busM.cycleCount), 32'd0);
        chk("midRunRst/start", 32'(busM.coreStart), 32'd0);

        // go held high through a whole run relaunches via IDLE.
        releaseReset();
        busM.go = 1'b1; busM.coreReady = 4'b1111; busM.coreDone = 4'b1111;
        step();
        chk("hold/busy", 32'(busM.busy), 32'd1);
        step();
        chk("hold/start", 32'(busM.coreStart), 32'hF);
        step();
        step();
        chk("hold/allDone", 32'(busM.allDone), 32'd1);
        chk("hold/count", 32'(busM.cycleCount), 32'd1);
        step();
        chk("hold/idle", 32'(busM.busy), 32'd0);
        step();
        chk("hold/relaunch", 32'(busM.busy), 32'd1);
        chk("hold/countCleared", 32'(busM.cycleCount), 32'd0);
        chk("hold/maskCleared", 32'(busM.doneMask), 32'd0);
        busM.go = 1'b0; busM.coreDone = 4'b0000;
        #2 rstN = 1'b0;
        releaseReset();
        step();

        // Directed vectors with hand-derived expectations.
        table_q.push_back(mkVec(0, 3, 5, 5, 9, 9, 4'b1111, 1'b0));
        table_q.push_back(mkVec(6, 1, 1, 1, 1, 1, 4'b1111, 1'b0));
        table_q.push_back(mkVec(2, 7, 2, 4, 3, 7, 4'b1111, 1'b0));
        table_q.push_back(mkVec(0, 4, 3, 2, 1, 4, 4'b1111, 1'b0));
        table_q.push_back(mkVec(1, 6, 6, 6, 6, 6, 4'b1111, 1'b0));
`ifdef MULTICORE_LAUNCH_CTRL_TIMEOUT_EN
        table_q.push_back(mkVec(0, 3, 5, 0, 9, 20, 4'b1011, 1'b1));
`endif
        foreach (table_q[i]) begin
            doRun(table_q[i], $sformatf("vec%0d", i));
        end

        // Random runs: the run ends on the edge where the last core first reports done.
        for (int r = 0; r < 25; r++) begin
            v.rdyDelay = 8'($urandom_range(0, 4));
            mx = 0;
            for (int c = 0; c < NC; c++) begin
                v.doneAt[c] = 8'($urandom_range(1, 12));
                if (int'(v.doneAt[c]) > mx) begin
                    mx = int'(v.doneAt[c]);
                end
            end
            v.expCount   = 8'(mx);
            v.expMask    = 4'b1111;
            v.expTimeout = 1'b0;
            doRun(v, $sformatf("rnd%0d", r));
        end

        // Single core, 4-bit counter: saturation at 15.
        busS.go = 1'b1; busS.coreReady = 1'b1; busS.coreDone = 1'b0;
        step();
        busS.go = 1'b0;
        step();
        chk("small/start", 32'(busS.coreStart), 32'd1);
        step();
        for (int n = 1; n <= 20; n++) begin
            step();
            chk("small/satCount", 32'(busS.cycleCount), 32'((n > 15) ? 15 : n));
        end
        chk("small/noDone", 32'(busS.allDone), 32'd0);
        busS.coreDone = 1'b1;
        step();
        busS.coreDone = 1'b0;
        chk("small/allDone", 32'(busS.allDone), 32'd1);
        chk("small/count", 32'(busS.cycleCount), 32'd15);
        chk("small/mask", 32'(busS.doneMask), 32'd1);
        step();
        chk("small/idle", 32'(busS.busy), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
